// File: rtl/regfile_fwd_sb_pkg.sv
// Shared definitions for the decode-stage register file: default widths and
// zero-extension helpers for the immediate and PC operand paths.
package regfile_fwd_sb_pkg;

  localparam int XLEN_DEF      = 32;
  localparam int REG_NUM_DEF   = 32;
  localparam int ADDR_SIZE_DEF = 5;
  localparam int NWR_DEF       = 2;
  localparam int IMM_W_DEF     = 11;
  localparam int PC_W_DEF      = 5;

  function automatic logic [XLEN_DEF-1:0] zext_imm(input logic [IMM_W_DEF-1:0] v);
    return {{(XLEN_DEF-IMM_W_DEF){1'b0}}, v};
  endfunction

  function automatic logic [XLEN_DEF-1:0] zext_pc(input logic [PC_W_DEF-1:0] v);
    return {{(XLEN_DEF-PC_W_DEF){1'b0}}, v};
  endfunction

endpackage

// File: rtl/regfile_fwd_sb_scoreboard.sv
// Per-register busy tracking: raises a stall when a used source still waits on
// an outstanding writer that is not being written back this cycle.
module regfile_scoreboard
  import regfile_fwd_sb_pkg::*;
#(
  parameter int REG_NUM   = REG_NUM_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int NWR       = NWR_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_SIZE-1:0]     D_ra,
  input  logic [ADDR_SIZE-1:0]     D_rb,
  input  logic                     D_ra_used,
  input  logic                     D_rb_used,
  input  logic [ADDR_SIZE-1:0]     D_rd,
  input  logic                     D_issue,
  input  logic [NWR-1:0]           WB_we,
  input  logic [NWR*ADDR_SIZE-1:0] WB_rd,
  output logic                     D_stall,
  output logic                     D_accept
);

  logic [REG_NUM-1:0] busy;
  logic [REG_NUM-1:0] busy_nxt;
  logic               wb_hit_a;
  logic               wb_hit_b;
  logic               pend_a;
  logic               pend_b;

  // A writeback landing this cycle is bypassed, so it cancels the hazard.
  always_comb begin
    wb_hit_a = 1'b0;
    wb_hit_b = 1'b0;
    for (int k = 0; k < NWR; k++) begin
      if (WB_we[k] && (WB_rd[k*ADDR_SIZE +: ADDR_SIZE] == D_ra)) wb_hit_a = 1'b1;
      if (WB_we[k] && (WB_rd[k*ADDR_SIZE +: ADDR_SIZE] == D_rb)) wb_hit_b = 1'b1;
    end
  end

  assign pend_a   = busy[D_ra] && !wb_hit_a;
  assign pend_b   = busy[D_rb] && !wb_hit_b;
  assign D_stall  = (D_ra_used && pend_a) || (D_rb_used && pend_b);
  assign D_accept = D_issue && !D_stall;

  // Clears first, then the accepted issue: a new writer outranks a retiring one.
  always_comb begin
    busy_nxt = busy;
    for (int k = 0; k < NWR; k++) begin
      if (WB_we[k] && (WB_rd[k*ADDR_SIZE +: ADDR_SIZE] != '0))
        busy_nxt[WB_rd[k*ADDR_SIZE +: ADDR_SIZE]] = 1'b0;
    end
    if (D_accept && (D_rd != '0)) busy_nxt[D_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

endmodule

// File: rtl/regfile_fwd_sb.sv
// Decode-stage register file with NWR write ports, write-first bypass on both
// read ports, operand muxes for immediate/PC, and a RAW-hazard scoreboard.
module regfile_fwd_sb
  import regfile_fwd_sb_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int REG_NUM   = REG_NUM_DEF,
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int NWR       = NWR_DEF,
  parameter int IMM_W     = IMM_W_DEF,
  parameter int PC_W      = PC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDR_SIZE-1:0]     D_ra,
  input  logic [ADDR_SIZE-1:0]     D_rb,
  input  logic                     D_ra_used,
  input  logic                     D_rb_used,
  input  logic [ADDR_SIZE-1:0]     D_rd,
  input  logic                     D_issue,
  input  logic [IMM_W-1:0]         D_imd,
  input  logic [PC_W-1:0]          D_pc,
  input  logic                     D_ld,
  input  logic                     D_str,
  input  logic                     D_brn,
  input  logic                     D_addi,
  input  logic [NWR-1:0]           WB_we,
  input  logic [NWR*ADDR_SIZE-1:0] WB_rd,
  input  logic [NWR*XLEN-1:0]      WB_data,
  output logic [XLEN-1:0]          D_a,
  output logic [XLEN-1:0]          D_b,
  output logic [XLEN-1:0]          D_a2,
  output logic [XLEN-1:0]          D_b2,
  output logic                     D_stall,
  output logic                     D_accept
);

  logic [XLEN-1:0]      regs     [REG_NUM];
  logic [ADDR_SIZE-1:0] wb_rd_k  [NWR];
  logic [XLEN-1:0]      wb_dat_k [NWR];
  logic                 use_imm;

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wb_rd_k[k]  = WB_rd[k*ADDR_SIZE +: ADDR_SIZE];
      wb_dat_k[k] = WB_data[k*XLEN +: XLEN];
    end
  end

  // Ascending port order lets the highest-numbered port win on a shared rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (WB_we[k] && (wb_rd_k[k] != '0)) regs[wb_rd_k[k]] <= wb_dat_k[k];
      end
    end
  end

  always_comb begin
    D_a2 = regs[D_ra];
    D_b2 = regs[D_rb];
    for (int k = 0; k < NWR; k++) begin
      if (WB_we[k] && (wb_rd_k[k] == D_ra)) D_a2 = wb_dat_k[k];
      if (WB_we[k] && (wb_rd_k[k] == D_rb)) D_b2 = wb_dat_k[k];
    end
    if (D_ra == '0) D_a2 = '0;
    if (D_rb == '0) D_b2 = '0;
  end

  assign use_imm = D_ld | D_str | D_brn | D_addi;
  assign D_b     = use_imm ? XLEN'(D_imd) : D_b2;
  assign D_a     = D_brn   ? XLEN'(D_pc)  : D_a2;

  regfile_scoreboard #(
    .REG_NUM   (REG_NUM),
    .ADDR_SIZE (ADDR_SIZE),
    .NWR       (NWR)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .D_ra      (D_ra),
    .D_rb      (D_rb),
    .D_ra_used (D_ra_used),
    .D_rb_used (D_rb_used),
    .D_rd      (D_rd),
    .D_issue   (D_issue),
    .WB_we     (WB_we),
    .WB_rd     (WB_rd),
    .D_stall   (D_stall),
    .D_accept  (D_accept)
  );

endmodule

// File: tb/tb_regfile_fwd_sb.sv
// Scoreboard bench for regfile_fwd_sb: a reference model predicts every output
// per cycle; directed scenarios add fixed-value checks, then a random phase.
module tb_regfile_fwd_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  D_ra, D_rb, D_rd;
  logic        D_ra_used, D_rb_used, D_issue;
  logic [10:0] D_imd;
  logic [4:0]  D_pc;
  logic        D_ld, D_str, D_brn, D_addi;
  logic [1:0]  WB_we;
  logic [9:0]  WB_rd;
  logic [63:0] WB_data;
  logic [31:0] D_a, D_b, D_a2, D_b2;
  logic        D_stall, D_accept;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a, b, a2, b2;
    logic        stall, accept;
  } exp_t;

  exp_t        exp_q [$];
  logic [31:0] mregs [32];
  logic        mbusy [32];

  regfile_fwd_sb dut (
    .clk(clk), .rst(rst), .D_ra(D_ra), .D_rb(D_rb), .D_ra_used(D_ra_used),
    .D_rb_used(D_rb_used), .D_rd(D_rd), .D_issue(D_issue), .D_imd(D_imd),
    .D_pc(D_pc), .D_ld(D_ld), .D_str(D_str), .D_brn(D_brn), .D_addi(D_addi),
    .WB_we(WB_we), .WB_rd(WB_rd), .WB_data(WB_data), .D_a(D_a), .D_b(D_b),
    .D_a2(D_a2), .D_b2(D_b2), .D_stall(D_stall), .D_accept(D_accept)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [4:0] wrd(input int k);
    return (k == 0) ? WB_rd[4:0] : WB_rd[9:5];
  endfunction

  function automatic logic [31:0] wdat(input int k);
    return (k == 0) ? WB_data[31:0] : WB_data[63:32];
  endfunction

  function automatic logic [31:0] m_raw(input logic [4:0] x);
    logic [31:0] r;
    if (x == 5'd0) return 32'd0;
    r = mregs[x];
    for (int k = 0; k < 2; k++) if (WB_we[k] && wrd(k) == x) r = wdat(k);
    return r;
  endfunction

  function automatic logic m_pend(input logic [4:0] x);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < 2; k++) if (WB_we[k] && wrd(k) == x) hit = 1'b1;
    return mbusy[x] && !hit;
  endfunction

  task automatic idle();
    D_ra = 0; D_rb = 0; D_rd = 0; D_ra_used = 0; D_rb_used = 0; D_issue = 0;
    D_imd = 0; D_pc = 0; D_ld = 0; D_str = 0; D_brn = 0; D_addi = 0;
    WB_we = 0; WB_rd = 0; WB_data = 0;
  endtask

  // Predict outputs for the inputs now applied, then compare at the falling edge.
  task automatic settle();
    exp_t e, g;
    e.a2     = m_raw(D_ra);
    e.b2     = m_raw(D_rb);
    e.stall  = (D_ra_used && m_pend(D_ra)) || (D_rb_used && m_pend(D_rb));
    e.accept = D_issue && !e.stall;
    e.b      = (D_ld | D_str | D_brn | D_addi) ? {21'd0, D_imd} : e.b2;
    e.a      = D_brn ? {27'd0, D_pc} : e.a2;
    exp_q.push_back(e);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd0, 32'd1);
    end else begin
      g = exp_q.pop_front();
      check("D_a2", D_a2, g.a2);
      check("D_b2", D_b2, g.b2);
      check("D_a", D_a, g.a);
      check("D_b", D_b, g.b);
      check("D_stall", {31'd0, D_stall}, {31'd0, g.stall});
      check("D_accept", {31'd0, D_accept}, {31'd0, g.accept});
    end
  endtask

  // Commit the model with the same held inputs the DUT sees at the next edge.
  task automatic adv();
    logic acc;
    acc = D_issue && !((D_ra_used && m_pend(D_ra)) || (D_rb_used && m_pend(D_rb)));
    if (rst) begin
      for (int i = 0; i < 32; i++) begin mregs[i] = 0; mbusy[i] = 0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (WB_we[k] && wrd(k) != 5'd0) begin
          mregs[wrd(k)] = wdat(k);
          mbusy[wrd(k)] = 1'b0;
        end
      end
      if (acc && D_rd != 5'd0) mbusy[D_rd] = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin mregs[i] = 0; mbusy[i] = 0; end
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: every register reads zero, no stall.
    for (int r = 1; r < 32; r++) begin
      idle(); D_ra = 5'(r); D_rb = 5'(r); D_ra_used = 1; D_rb_used = 1;
      settle();
      check("rst_a2", D_a2, 32'd0);
      adv();
    end

    // Write-first bypass, then registered value.
    idle(); WB_we = 2'b01; WB_rd = {5'd0, 5'd5}; WB_data = {32'd0, 32'hDEADBEEF}; D_ra = 5;
    settle(); check("bypass_r5", D_a2, 32'hDEADBEEF); adv();
    idle(); D_ra = 5;
    settle(); check("held_r5", D_a2, 32'hDEADBEEF); adv();

    // r0 stays zero; port 1 wins on a shared destination.
    idle(); WB_we = 2'b01; WB_rd = {5'd0, 5'd0}; WB_data = {32'd0, 32'h1234}; D_ra = 0;
    settle(); check("r0_bypass", D_a2, 32'd0); adv();
    idle(); D_ra = 0; settle(); check("r0_read", D_a2, 32'd0); adv();
    idle(); WB_we = 2'b11; WB_rd = {5'd7, 5'd7}; WB_data = {32'h22, 32'h11}; D_rb = 7;
    settle(); check("prio_bypass", D_b2, 32'h22); adv();
    idle(); D_rb = 7; settle(); check("prio_r7", D_b2, 32'h22); adv();

    // RAW hazard and same-cycle writeback resolution.
    idle(); D_issue = 1; D_rd = 3;
    settle(); check("issue_r3", {31'd0, D_accept}, 32'd1); adv();
    idle(); D_ra = 3; D_ra_used = 1; D_issue = 1; D_rd = 4;
    settle(); check("raw_stall", {31'd0, D_stall}, 32'd1);
    check("raw_noacc", {31'd0, D_accept}, 32'd0); adv();
    WB_we = 2'b01; WB_rd = {5'd0, 5'd3}; WB_data = {32'd0, 32'h55};
    settle(); check("wb_unstall", {31'd0, D_stall}, 32'd0);
    check("wb_fwd_r3", D_a2, 32'h55); adv();

    // Operand muxes.
    idle(); D_rb = 7; D_imd = 11'h7FF; D_addi = 1;
    settle(); check("addi_b", D_b, 32'h000007FF); check("addi_b2", D_b2, 32'h22); adv();
    idle(); D_ra = 5; D_rb = 7; D_imd = 11'h7FF; D_brn = 1; D_pc = 5'h1F;
    settle(); check("brn_a", D_a, 32'h1F); check("brn_b", D_b, 32'h7FF);
    check("brn_a2", D_a2, 32'hDEADBEEF); adv();

    // Set beats clear, then reset mid-operation drops writers and the WB in that cycle.
    idle(); D_issue = 1; D_rd = 9; WB_we = 2'b01; WB_rd = {5'd0, 5'd9}; WB_data = {32'd0, 32'h99};
    settle(); check("setclr_acc", {31'd0, D_accept}, 32'd1); adv();
    idle(); D_ra = 9; D_ra_used = 1;
    settle(); check("setclr_stall", {31'd0, D_stall}, 32'd1); adv();
    idle(); rst = 1; WB_we = 2'b01; WB_rd = {5'd0, 5'd9}; WB_data = {32'd0, 32'hAA};
    settle(); adv();
    rst = 0; idle(); D_ra = 9; D_ra_used = 1;
    settle(); check("post_rst_r9", D_a2, 32'd0);
    check("post_rst_stall", {31'd0, D_stall}, 32'd0); adv();

    // Random traffic on a small register window to provoke hazards and collisions.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst       = ($urandom_range(0, 60) == 0);
      D_ra      = 5'($urandom_range(0, 7));
      D_rb      = 5'($urandom_range(0, 7));
      D_ra_used = 1'($urandom_range(0, 1));
      D_rb_used = 1'($urandom_range(0, 1));
      D_rd      = 5'($urandom_range(0, 7));
      D_issue   = 1'($urandom_range(0, 1));
      D_imd     = 11'($urandom);
      D_pc      = 5'($urandom);
      D_ld      = ($urandom_range(0, 5) == 0);
      D_str     = ($urandom_range(0, 5) == 0);
      D_brn     = ($urandom_range(0, 4) == 0);
      D_addi    = ($urandom_range(0, 5) == 0);
      WB_we     = 2'($urandom_range(0, 3));
      WB_rd     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      WB_data   = {$urandom, $urandom};
      settle();
      adv();
    end
    rst = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
